// File: rtl/cdb_arbiter_pkg.sv
// Shared widths, source encodings and payload layouts for the result-broadcast arbiter.
package cdb_arbiter_pkg;

    localparam int unsigned CDB_ROB_W = 4;
    localparam int unsigned CDB_VAL_W = 32;

    localparam logic CDB_SRC_ALU = 1'b0;
    localparam logic CDB_SRC_LSB = 1'b1;

    typedef struct packed {
        logic [CDB_ROB_W-1:0] rob_pos;
        logic [CDB_VAL_W-1:0] val;
        logic                 jump;
        logic [CDB_VAL_W-1:0] pc;
    } alu_entry_t;

    typedef struct packed {
        logic [CDB_ROB_W-1:0] rob_pos;
        logic [CDB_VAL_W-1:0] val;
    } lsb_entry_t;

    typedef struct packed {
        logic                 valid;
        logic                 src;
        logic [CDB_ROB_W-1:0] rob_pos;
        logic [CDB_VAL_W-1:0] val;
        logic                 jump;
        logic [CDB_VAL_W-1:0] pc;
    } cdb_bus_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer handshakes, reorder-buffer controls and the broadcast bus of the arbiter.
interface cdb_arbiter_if #(
    parameter int unsigned ROB_W = cdb_arbiter_pkg::CDB_ROB_W
);
    import cdb_arbiter_pkg::*;

    logic                 rdy;
    logic                 rollback;
    logic [ROB_W-1:0]     head_rob_pos;

    logic                 alu_valid;
    logic                 alu_ready;
    logic [ROB_W-1:0]     alu_rob_pos;
    logic [CDB_VAL_W-1:0] alu_val;
    logic                 alu_jump;
    logic [CDB_VAL_W-1:0] alu_pc;

    logic                 lsb_valid;
    logic                 lsb_ready;
    logic [ROB_W-1:0]     lsb_rob_pos;
    logic [CDB_VAL_W-1:0] lsb_val;

    logic                 cdb_valid;
    logic                 cdb_src;
    logic [ROB_W-1:0]     cdb_rob_pos;
    logic [CDB_VAL_W-1:0] cdb_val;
    logic                 cdb_jump;
    logic [CDB_VAL_W-1:0] cdb_pc;

    modport master (
        output rdy, rollback, head_rob_pos,
        output alu_valid, alu_rob_pos, alu_val, alu_jump, alu_pc,
        output lsb_valid, lsb_rob_pos, lsb_val,
        input  alu_ready, lsb_ready,
        input  cdb_valid, cdb_src, cdb_rob_pos, cdb_val, cdb_jump, cdb_pc
    );

    modport slave (
        input  rdy, rollback, head_rob_pos,
        input  alu_valid, alu_rob_pos, alu_val, alu_jump, alu_pc,
        input  lsb_valid, lsb_rob_pos, lsb_val,
        output alu_ready, lsb_ready,
        output cdb_valid, cdb_src, cdb_rob_pos, cdb_val, cdb_jump, cdb_pc
    );

endinterface

// File: rtl/cdb_fifo.sv
// Per-source result FIFO with flush and global enable; occupancy kept in a count one bit
// wider than the pointers so full and empty never alias.
module cdb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   flush,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign do_push   = en && !flush && push && !full;
    assign do_pop    = en && !flush && pop && !empty;
    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (en && flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while counted as occupied.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Arbitrates the ALU and LSB result FIFOs onto one registered broadcast bus, giving the
// reorder-buffer head result priority and round-robin otherwise.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ROB_W = CDB_ROB_W
) (
    input  logic         clk,
    input  logic         rst,
    cdb_arbiter_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned ALU_W = $bits(alu_entry_t);
    localparam int unsigned LSB_W = $bits(lsb_entry_t);

    alu_entry_t       alu_in, alu_head;
    lsb_entry_t       lsb_in, lsb_head;
    logic [CNT_W-1:0] alu_count, lsb_count;
    logic             alu_empty, lsb_empty;
    logic             accept_en;
    logic             alu_pop, lsb_pop;
    logic [ROB_W-1:0] head_pos;

    logic             grant;
    logic             winner;
    logic             alu_match, lsb_match;

    cdb_bus_t         cdb_q, cdb_d;
    logic             rr_last_q, rr_last_d;

    assign accept_en     = bus.rdy && !bus.rollback;
    assign bus.alu_ready = accept_en && (alu_count != CNT_W'(DEPTH));
    assign bus.lsb_ready = accept_en && (lsb_count != CNT_W'(DEPTH));
    assign head_pos      = bus.head_rob_pos;

    assign alu_in = '{rob_pos: bus.alu_rob_pos, val: bus.alu_val,
                      jump: bus.alu_jump, pc: bus.alu_pc};
    assign lsb_in = '{rob_pos: bus.lsb_rob_pos, val: bus.lsb_val};

    cdb_fifo #(.DEPTH(DEPTH), .W(ALU_W)) u_alu_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .en        (bus.rdy),
        .flush     (bus.rollback),
        .push      (bus.alu_valid && bus.alu_ready),
        .push_data (alu_in),
        .pop       (alu_pop),
        .head_data (alu_head),
        .count     (alu_count),
        .empty     (alu_empty)
    );

    cdb_fifo #(.DEPTH(DEPTH), .W(LSB_W)) u_lsb_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .en        (bus.rdy),
        .flush     (bus.rollback),
        .push      (bus.lsb_valid && bus.lsb_ready),
        .push_data (lsb_in),
        .pop       (lsb_pop),
        .head_data (lsb_head),
        .count     (lsb_count),
        .empty     (lsb_empty)
    );

    // Head match beats round-robin; a double match falls back to round-robin.
    always_comb begin
        alu_match = !alu_empty && (alu_head.rob_pos == head_pos);
        lsb_match = !lsb_empty && (lsb_head.rob_pos == head_pos);
        grant     = 1'b1;
        winner    = CDB_SRC_ALU;
        if (alu_match != lsb_match) begin
            winner = lsb_match ? CDB_SRC_LSB : CDB_SRC_ALU;
        end else if (!alu_empty && !lsb_empty) begin
            winner = !rr_last_q;
        end else if (!alu_empty) begin
            winner = CDB_SRC_ALU;
        end else if (!lsb_empty) begin
            winner = CDB_SRC_LSB;
        end else begin
            grant = 1'b0;
        end
    end

    always_comb begin
        cdb_d     = cdb_q;
        rr_last_d = rr_last_q;
        alu_pop   = 1'b0;
        lsb_pop   = 1'b0;
        if (bus.rdy) begin
            if (bus.rollback || !grant) begin
                cdb_d.valid = 1'b0;
            end else if (winner == CDB_SRC_LSB) begin
                lsb_pop   = 1'b1;
                rr_last_d = CDB_SRC_LSB;
                cdb_d     = '{valid: 1'b1, src: CDB_SRC_LSB, rob_pos: lsb_head.rob_pos,
                              val: lsb_head.val, jump: 1'b0, pc: '0};
            end else begin
                alu_pop   = 1'b1;
                rr_last_d = CDB_SRC_ALU;
                cdb_d     = '{valid: 1'b1, src: CDB_SRC_ALU, rob_pos: alu_head.rob_pos,
                              val: alu_head.val, jump: alu_head.jump, pc: alu_head.pc};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_q     <= '0;
            rr_last_q <= CDB_SRC_LSB;
        end else begin
            cdb_q     <= cdb_d;
            rr_last_q <= rr_last_d;
        end
    end

    assign bus.cdb_valid   = cdb_q.valid;
    assign bus.cdb_src     = cdb_q.src;
    assign bus.cdb_rob_pos = cdb_q.rob_pos;
    assign bus.cdb_val     = cdb_q.val;
    assign bus.cdb_jump    = cdb_q.jump;
    assign bus.cdb_pc      = cdb_q.pc;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: constant vector table, directed corner sequences and random
// traffic checked against a queue-based reference model.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.ROB_W(4)) bus();

    cdb_arbiter #(.DEPTH(DEPTH), .ROB_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0]  rob;
        logic [31:0] val;
        logic        jump;
        logic [31:0] pc;
    } ent_t;

    ent_t        aq[$];
    ent_t        lq[$];
    logic        m_rr;
    logic [70:0] m_cdb;

    typedef struct {
        logic        rdy;
        logic [3:0]  head;
        logic        av;
        logic [3:0]  arob;
        logic [31:0] aval;
        logic        aj;
        logic [31:0] apc;
        logic        lv;
        logic [3:0]  lrob;
        logic [31:0] lval;
        logic        ea;
        logic        el;
        logic [70:0] ecdb;
    } vec_t;

    vec_t tbl[17];

    function automatic logic [70:0] pk(input logic v, input logic s, input logic [3:0] r,
                                       input logic [31:0] val, input logic j,
                                       input logic [31:0] pc);
        return {v, s, r, val, j, pc};
    endfunction

    function automatic logic [70:0] dut_cdb();
        return {bus.cdb_valid, bus.cdb_src, bus.cdb_rob_pos, bus.cdb_val,
                bus.cdb_jump, bus.cdb_pc};
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_cdb(input string name, input logic [70:0] act, input logic [70:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        aq.delete();
        lq.delete();
        m_rr  = 1'b1;
        m_cdb = '0;
    endtask

    function automatic logic m_ready(input logic is_lsb);
        int n;
        n = is_lsb ? lq.size() : aq.size();
        return bus.rdy && !bus.rollback && (n < int'(DEPTH));
    endfunction

    // One rising edge of the reference: choose from current heads, then accept new inputs.
    task automatic model_step();
        logic a_acc, l_acc, an, ln, am, lm, g, w;
        ent_t e;
        if (!bus.rdy) return;
        if (bus.rollback) begin
            aq.delete();
            lq.delete();
            m_cdb[70] = 1'b0;
            return;
        end
        a_acc = bus.alu_valid && m_ready(1'b0);
        l_acc = bus.lsb_valid && m_ready(1'b1);
        an = aq.size() > 0;
        ln = lq.size() > 0;
        am = an && (aq[0].rob == bus.head_rob_pos);
        lm = ln && (lq[0].rob == bus.head_rob_pos);
        g  = 1'b1;
        w  = 1'b0;
        if (am != lm)        w = lm;
        else if (an && ln)   w = !m_rr;
        else if (an)         w = 1'b0;
        else if (ln)         w = 1'b1;
        else                 g = 1'b0;
        if (g) begin
            e     = w ? lq.pop_front() : aq.pop_front();
            m_cdb = pk(1'b1, w, e.rob, e.val, e.jump, e.pc);
            m_rr  = w;
        end else begin
            m_cdb[70] = 1'b0;
        end
        if (a_acc) aq.push_back('{bus.alu_rob_pos, bus.alu_val, bus.alu_jump, bus.alu_pc});
        if (l_acc) lq.push_back('{bus.lsb_rob_pos, bus.lsb_val, 1'b0, 32'h0});
    endtask

    task automatic drive(input logic rdy, input logic rb, input logic [3:0] head,
                         input logic av, input logic [3:0] arob, input logic [31:0] aval,
                         input logic aj, input logic [31:0] apc,
                         input logic lv, input logic [3:0] lrob, input logic [31:0] lval);
        bus.rdy          = rdy;
        bus.rollback     = rb;
        bus.head_rob_pos = head;
        bus.alu_valid    = av;
        bus.alu_rob_pos  = arob;
        bus.alu_val      = aval;
        bus.alu_jump     = aj;
        bus.alu_pc       = apc;
        bus.lsb_valid    = lv;
        bus.lsb_rob_pos  = lrob;
        bus.lsb_val      = lval;
    endtask

    task automatic idle(input logic [3:0] head);
        drive(1'b1, 1'b0, head, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0);
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cycle(input string tag);
        #1;
        check_bit({tag, " alu_ready"}, bus.alu_ready, m_ready(1'b0));
        check_bit({tag, " lsb_ready"}, bus.lsb_ready, m_ready(1'b1));
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_cdb({tag, " cdb"}, dut_cdb(), m_cdb);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic exp_src;
        int   ai;
        logic exp_acc;

        // rdy, head, av, arob, aval, aj, apc, lv, lrob, lval, ea, el, expected cdb after edge
        tbl[0]  = '{1'b1, 4'd0,  1'b1, 4'd3, 32'h1234, 1'b1, 32'h100, 1'b0, 4'd0, 32'h0,  1'b1, 1'b1, pk(1'b0, 1'b0, 4'd0, 32'h0,    1'b0, 32'h0)};
        tbl[1]  = '{1'b1, 4'd0,  1'b0, 4'd0, 32'h0,    1'b0, 32'h0,   1'b0, 4'd0, 32'h0,  1'b1, 1'b1, pk(1'b1, 1'b0, 4'd3, 32'h1234, 1'b1, 32'h100)};
        tbl[2]  = '{1'b1, 4'd0,  1'b0, 4'd0, 32'h0,    1'b0, 32'h0,   1'b0, 4'd0, 32'h0,  1'b1, 1'b1, pk(1'b0, 1'b0, 4'd3, 32'h1234, 1'b1, 32'h100)};
        tbl[3]  = '{1'b1, 4'd5,  1'b1, 4'd6, 32'h66,   1'b0, 32'h200, 1'b1, 4'd5, 32'h55, 1'b1, 1'b1, pk(1'b0, 1'b0, 4'd3, 32'h1234, 1'b1, 32'h100)};
        tbl[4]  = '{1'b1, 4'd5,  1'b0, 4'd0, 32'h0,    1'b0, 32'h0,   1'b0, 4'd0, 32'h0,  1'b1, 1'b1, pk(1'b1, 1'b1, 4'd5, 32'h55,   1'b0, 32'h0)};
        tbl[5]  = '{1'b1, 4'd6,  1'b0, 4'd0, 32'h0,    1'b0, 32'h0,   1'b0, 4'd0, 32'h0,  1'b1, 1'b1, pk(1'b1, 1'b0, 4'd6, 32'h66,   1'b0, 32'h200)};
        tbl[6]  = '{1'b1, 4'd15, 1'b0, 4'd0, 32'h0,    1'b0, 32'h0,   1'b1, 4'd9, 32'h99, 1'b1, 1'b1, pk(1'b0, 1'b0, 4'd6, 32'h66,   1'b0, 32'h200)};
        tbl[7]  = '{1'b1, 4'd15, 1'b0, 4'd0, 32'h0,    1'b0, 32'h0,   1'b0, 4'd0, 32'h0,  1'b1, 1'b1, pk(1'b1, 1'b1, 4'd9, 32'h99,   1'b0, 32'h0)};
        tbl[8]  = '{1'b1, 4'd5,  1'b1, 4'd6, 32'ha6,   1'b1, 32'h300, 1'b1, 4'd5, 32'hb5, 1'b1, 1'b1, pk(1'b0, 1'b1, 4'd9, 32'h99,   1'b0, 32'h0)};
        tbl[9]  = '{1'b1, 4'd5,  1'b0, 4'd0, 32'h0,    1'b0, 32'h0,   1'b0, 4'd0, 32'h0,  1'b1, 1'b1, pk(1'b1, 1'b1, 4'd5, 32'hb5,   1'b0, 32'h0)};
        tbl[10] = '{1'b1, 4'd15, 1'b0, 4'd0, 32'h0,    1'b0, 32'h0,   1'b0, 4'd0, 32'h0,  1'b1, 1'b1, pk(1'b1, 1'b0, 4'd6, 32'ha6,   1'b1, 32'h300)};
        tbl[11] = '{1'b1, 4'd15, 1'b0, 4'd0, 32'h0,    1'b0, 32'h0,   1'b0, 4'd0, 32'h0,  1'b1, 1'b1, pk(1'b0, 1'b0, 4'd6, 32'ha6,   1'b1, 32'h300)};
        tbl[12] = '{1'b1, 4'd15, 1'b1, 4'd1, 32'h11,   1'b0, 32'h0,   1'b1, 4'd2, 32'h22, 1'b1, 1'b1, pk(1'b0, 1'b0, 4'd6, 32'ha6,   1'b1, 32'h300)};
        tbl[13] = '{1'b0, 4'd15, 1'b1, 4'd7, 32'h77,   1'b0, 32'h0,   1'b0, 4'd0, 32'h0,  1'b0, 1'b0, pk(1'b0, 1'b0, 4'd6, 32'ha6,   1'b1, 32'h300)};
        tbl[14] = '{1'b1, 4'd15, 1'b0, 4'd0, 32'h0,    1'b0, 32'h0,   1'b0, 4'd0, 32'h0,  1'b1, 1'b1, pk(1'b1, 1'b1, 4'd2, 32'h22,   1'b0, 32'h0)};
        tbl[15] = '{1'b1, 4'd15, 1'b0, 4'd0, 32'h0,    1'b0, 32'h0,   1'b0, 4'd0, 32'h0,  1'b1, 1'b1, pk(1'b1, 1'b0, 4'd1, 32'h11,   1'b0, 32'h0)};
        tbl[16] = '{1'b1, 4'd15, 1'b0, 4'd0, 32'h0,    1'b0, 32'h0,   1'b0, 4'd0, 32'h0,  1'b1, 1'b1, pk(1'b0, 1'b0, 4'd1, 32'h11,   1'b0, 32'h0)};

        // Reset state
        idle(4'd0);
        model_reset();
        repeat (2) @(negedge clk);
        check_cdb("reset cdb", dut_cdb(), 71'h0);
        check_bit("reset alu_ready", bus.alu_ready, 1'b1);
        rst = 1'b1;

        // Constant vector table: single result latency, head priority, rdy-low rejection
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].rdy, 1'b0, tbl[i].head, tbl[i].av, tbl[i].arob, tbl[i].aval,
                  tbl[i].aj, tbl[i].apc, tbl[i].lv, tbl[i].lrob, tbl[i].lval);
            #1;
            check_bit($sformatf("vec%0d alu_ready", i), bus.alu_ready, tbl[i].ea);
            check_bit($sformatf("vec%0d lsb_ready", i), bus.lsb_ready, tbl[i].el);
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_cdb($sformatf("vec%0d cdb", i), dut_cdb(), tbl[i].ecdb);
        end

        // Both sources streaming with a never-matching head: strict alternation, LSB first
        exp_src = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b0, 4'd15, 1'b1, 4'(i % 8), 32'h5000 + 32'(i), 1'b0, 32'h0,
                  1'b1, 4'(i % 8), 32'h6000 + 32'(i));
            cycle("stream");
            if (m_cdb[70]) begin
                check_bit("stream alternation", bus.cdb_src, exp_src);
                exp_src = !exp_src;
            end
        end

        // Rollback with both FIFOs populated; inputs offered in that cycle are dropped
        drive(1'b1, 1'b1, 4'd15, 1'b1, 4'd1, 32'hdead, 1'b0, 32'h0, 1'b1, 4'd2, 32'hbeef);
        #1;
        check_bit("rollback alu_ready", bus.alu_ready, 1'b0);
        check_bit("rollback lsb_ready", bus.lsb_ready, 1'b0);
        cycle("rollback");
        for (int i = 0; i < 3; i++) begin
            idle(4'd15);
            cycle("post-rollback");
            check_bit("post-rollback valid", bus.cdb_valid, 1'b0);
        end
        drive(1'b1, 1'b0, 4'd15, 1'b1, 4'd2, 32'hc0de, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0);
        cycle("after-rollback push");
        idle(4'd15);
        cycle("after-rollback grant");
        check_cdb("after-rollback result", dut_cdb(), pk(1'b1, 1'b0, 4'd2, 32'hc0de, 1'b0, 32'h0));
        idle(4'd15);
        cycle("after-rollback idle");

        // ALU FIFO fills while LSB keeps winning by head match; 10 entries exercise wrap
        ai = 0;
        for (int k = 0; k < 22; k++) begin
            drive(1'b1, 1'b0, 4'd8, (k >= 1) && (ai < 10), 4'd2, 32'ha000 + 32'(ai), 1'b1,
                  32'h400 + 32'(ai), k <= 5, 4'd8, 32'hb000 + 32'(k));
            exp_acc = bus.alu_valid && m_ready(1'b0);
            #1;
            if (k == 5 || k == 7) check_bit($sformatf("full k%0d alu_ready", k), bus.alu_ready, 1'b0);
            if (k == 8) check_bit("full reopen alu_ready", bus.alu_ready, 1'b1);
            cycle("full");
            if (exp_acc) ai++;
        end
        check_bit("full all ten accepted", ai == 10, 1'b1);

        // rdy low freezes a live broadcast, then reset clears it without a clock edge
        drive(1'b1, 1'b0, 4'd15, 1'b1, 4'd1, 32'hd1, 1'b0, 32'h0, 1'b1, 4'd2, 32'hd2);
        cycle("pre-freeze push");
        idle(4'd15);
        cycle("pre-freeze grant");
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 4'd15, 1'b1, 4'd3, 32'hd3, 1'b0, 32'h0, 1'b1, 4'd4, 32'hd4);
            #1;
            check_bit("frozen alu_ready", bus.alu_ready, 1'b0);
            check_bit("frozen lsb_ready", bus.lsb_ready, 1'b0);
            cycle("frozen");
            check_bit("frozen valid", bus.cdb_valid, 1'b1);
        end
        #2;
        rst = 1'b0;
        #1;
        check_cdb("async reset cdb", dut_cdb(), 71'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
                  4'($urandom_range(0, 15)), 1'($urandom), 4'($urandom_range(0, 15)),
                  $urandom, 1'($urandom), $urandom, 1'($urandom),
                  4'($urandom_range(0, 15)), $urandom);
            cycle("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
